eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer_if.sv | 14 +
 rtl/eth_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_eth_tx_framer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - payload input, frame status and byte output of eth_tx_framer
`timescale 1ns/1ps
interface eth_tx_framer_if;
    logic [7:0] data;
    logic       tx_enable;
    logic       tx_ready;
    logic       active;
    logic       dropped;
    logic [7:0] tx_data;
    logic       tx_en;

    modport master (input data, tx_enable, output tx_ready, active, dropped, tx_data, tx_en);
    modport slave  (output data, tx_enable, input tx_ready, active, dropped, tx_data, tx_en);
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - byte-wide Ethernet TX framer: preamble/SFD, zero pad, IFG; CRC-32 FCS when ETH_TX_FCS_EN is defined
`timescale 1ns/1ps
module eth_tx_framer #(
    parameter int PREAMBLE_LEN   = 8,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_DATA_BYTES = 60
) (
    input  logic            clock,
    input  logic            reset,
    eth_tx_framer_if.master bus
);
    localparam int CW = (MIN_DATA_BYTES > 0) ? $clog2(MIN_DATA_BYTES + 1) : 1;
    localparam int GW = $clog2(IFG_BYTES + 1);
    localparam logic [CW-1:0] MIN_C     = CW'(MIN_DATA_BYTES);
    localparam logic [CW-1:0] CNT_START = (MIN_DATA_BYTES > 0) ? CW'(1) : '0;
    localparam logic [GW-1:0] IFG_C     = GW'(IFG_BYTES);
    localparam logic [3:0]    DRAIN_C   = 4'(PREAMBLE_LEN - 1);

`ifdef ETH_TX_FCS_EN
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAD, S_FCS, S_GAP} state_t;
    localparam state_t S_TAIL = S_FCS;

    logic [31:0]             r_crc;
    logic [1:0]              r_fidx;
    logic [PREAMBLE_LEN-1:0] r_sv;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction
`else
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_PAD, S_GAP} state_t;
    localparam state_t S_TAIL = S_GAP;
`endif

    state_t        r_state;
    logic [7:0]    r_sr [PREAMBLE_LEN];
    logic          r_closed;
    logic [3:0]    r_drain;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_en_d;
    logic          r_block;
    logic [7:0]    r_tx_data;
    logic          r_tx_en;
    logic          r_active;
    logic          r_dropped;
    logic          r_ready;

    logic w_busy;
    logic w_start;
    logic w_take;

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_SEND);
    assign w_start = (r_state == S_IDLE) && bus.tx_enable && !r_block;
    assign w_take  = !r_closed && bus.tx_enable;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_closed  <= 1'b0;
            r_drain   <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_en_d    <= 1'b0;
            r_block   <= 1'b0;
            r_tx_data <= '0;
            r_tx_en   <= 1'b0;
            r_active  <= 1'b0;
            r_dropped <= 1'b0;
            r_ready   <= 1'b1;
            for (int i = 0; i < PREAMBLE_LEN; i++) r_sr[i] <= '0;
`ifdef ETH_TX_FCS_EN
            r_crc  <= '1;
            r_fidx <= '0;
            r_sv   <= '0;
`endif
        end else begin
            r_en_d    <= bus.tx_enable;
            r_dropped <= w_busy && bus.tx_enable && !r_en_d;
            // A start refused during PAD/FCS/GAP stays refused until tx_enable is seen low in IDLE
            if (w_busy && bus.tx_enable)
                r_block <= 1'b1;
            else if (r_state == S_IDLE && !bus.tx_enable)
                r_block <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tx_en   <= 1'b0;
                    r_tx_data <= 8'h00;
                    if (w_start) begin
                        // First preamble byte goes straight out; the rest queue ahead of D0
                        for (int i = 0; i < PREAMBLE_LEN - 1; i++)
                            r_sr[i] <= (i == PREAMBLE_LEN - 2) ? 8'hD5 : 8'h55;
                        r_sr[PREAMBLE_LEN-1] <= bus.data;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= 8'h55;
                        r_active  <= 1'b1;
                        r_cnt     <= CNT_START;
                        r_closed  <= 1'b0;
                        r_drain   <= '0;
                        r_gap     <= '0;
                        r_state   <= S_SEND;
`ifdef ETH_TX_FCS_EN
                        r_sv   <= {1'b1, {(PREAMBLE_LEN-1){1'b0}}};
                        r_crc  <= '1;
                        r_fidx <= '0;
`endif
                    end
                end
                S_SEND: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= r_sr[0];
                    for (int i = 0; i < PREAMBLE_LEN - 1; i++) r_sr[i] <= r_sr[i+1];
                    r_sr[PREAMBLE_LEN-1] <= w_take ? bus.data : 8'h00;
`ifdef ETH_TX_FCS_EN
                    if (r_sv[0]) r_crc <= crc_byte(r_crc, r_sr[0]);
                    r_sv <= {w_take, r_sv[PREAMBLE_LEN-1:1]};
`endif
                    if (!r_closed) begin
                        if (bus.tx_enable) begin
                            if (r_cnt < MIN_C) r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_closed <= 1'b1;
                            r_drain  <= DRAIN_C;
                        end
                    end else begin
                        r_drain <= r_drain - 1'b1;
                        if (r_drain == 4'd1) begin
                            r_ready <= 1'b0;
                            r_state <= (r_cnt < MIN_C) ? S_PAD : S_TAIL;
                        end
                    end
                end
                S_PAD: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= 8'h00;
                    r_cnt     <= r_cnt + 1'b1;
`ifdef ETH_TX_FCS_EN
                    r_crc <= crc_byte(r_crc, 8'h00);
`endif
                    if (r_cnt == MIN_C - 1'b1) r_state <= S_TAIL;
                end
`ifdef ETH_TX_FCS_EN
                S_FCS: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= ~r_crc[7:0];
                    r_crc     <= {8'h00, r_crc[31:8]};
                    r_fidx    <= r_fidx + 1'b1;
                    if (r_fidx == 2'd3) r_state <= S_GAP;
                end
`endif
                S_GAP: begin
                    r_tx_en   <= 1'b0;
                    r_tx_data <= 8'h00;
                    if (r_gap == IFG_C) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                        r_ready  <= 1'b1;
                        r_gap    <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_en    = r_tx_en;
    assign bus.active   = r_active;
    assign bus.dropped  = r_dropped;
    assign bus.tx_ready = r_ready;
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - scoreboard bench for eth_tx_framer (default and PREAMBLE_LEN=2/IFG_BYTES=1/MIN_DATA_BYTES=0 builds)
`timescale 1ns/1ps
module tb_eth_tx_framer;
`ifdef ETH_TX_FCS_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    typedef struct { int d; logic [7:0] b; } exp_t;
    typedef struct { int d; int rise; int len; } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    eth_tx_framer_if if0();
    eth_tx_framer_if if1();

    eth_tx_framer #(.PREAMBLE_LEN(8), .IFG_BYTES(12), .MIN_DATA_BYTES(60)) dut0 (
        .clock(clk), .reset(rst), .bus(if0.master));
    eth_tx_framer #(.PREAMBLE_LEN(2), .IFG_BYTES(1), .MIN_DATA_BYTES(0)) dut1 (
        .clock(clk), .reset(rst), .bus(if1.master));

    logic [1:0] en = 2'b00;
    logic [7:0] din [2];
    assign if0.tx_enable = en[0];
    assign if1.tx_enable = en[1];
    assign if0.data = din[0];
    assign if1.data = din[1];

    logic [1:0] m_en, m_act, m_rdy, m_drop;
    logic [7:0] m_data [2];
    assign m_en   = {if1.tx_en, if0.tx_en};
    assign m_act  = {if1.active, if0.active};
    assign m_rdy  = {if1.tx_ready, if0.tx_ready};
    assign m_drop = {if1.dropped, if0.dropped};
    assign m_data[0] = if0.tx_data;
    assign m_data[1] = if1.tx_data;

    exp_t       exp_q [$];
    frm_t       frm_q [$];
    int         drop_q [$];
    logic [7:0] pl [$];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic int pl_of(input int d);  return (d == 0) ? 8 : 2;  endfunction
    function automatic int ifg_of(input int d); return (d == 0) ? 12 : 1; endfunction
    function automatic int min_of(input int d); return (d == 0) ? 60 : 0; endfunction

    function automatic logic [31:0] crc32(input logic [7:0] q [$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    task automatic fail_now(input string msg);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    task automatic push_b(input int d, input logic [7:0] b);
        exp_t e;
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every transmitted byte, frame start cycle, tx_en length and gap length
    int   run [2]     = '{0, 0};
    int   gapc [2]    = '{0, 0};
    int   cur_len [2] = '{0, 0};
    int   last_hi [2] = '{-1, -1};
    logic prev_en [2] = '{1'b0, 1'b0};
    logic prev_act [2] = '{1'b0, 1'b0};
    logic in_gap [2]  = '{1'b0, 1'b0};

    always @(negedge clk) begin : monitor
        exp_t e;
        frm_t f;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                run[d] = 0; gapc[d] = 0; in_gap[d] = 1'b0;
                prev_en[d] = 1'b0; prev_act[d] = 1'b0; last_hi[d] = -1;
            end else begin
                if (m_drop[d]) begin
                    if (drop_q.size() == 0 || drop_q[0] != d)
                        fail_now($sformatf("d%0d dropped: got pulse at cycle %0d, expected none", d, cyc));
                    else begin
                        n_cmp++;
                        void'(drop_q.pop_front());
                    end
                end
                if (m_en[d] && !prev_en[d]) begin
                    if (frm_q.size() == 0) begin
                        fail_now($sformatf("d%0d frame start: got start at cycle %0d, expected none", d, cyc));
                        cur_len[d] = -1;
                    end else begin
                        f = frm_q.pop_front();
                        chk($sformatf("d%0d frame owner", d), d, f.d);
                        chk($sformatf("d%0d start cycle", d), cyc, f.rise);
                        cur_len[d] = f.len;
                        if (last_hi[d] >= 0)
                            chk($sformatf("d%0d spacing>=ifg+1 (gap %0d)", d, cyc - last_hi[d]),
                                (cyc - last_hi[d]) >= ifg_of(d) + 1, 1);
                    end
                end
                if (m_en[d]) begin
                    if (exp_q.size() == 0)
                        fail_now($sformatf("d%0d byte %0d: got %0h, expected no byte", d, run[d], m_data[d]));
                    else begin
                        e = exp_q.pop_front();
                        chk($sformatf("d%0d byte owner", d), d, e.d);
                        chk($sformatf("d%0d byte %0d", d, run[d]), m_data[d], e.b);
                    end
                    run[d]++;
                    last_hi[d] = cyc;
                end
                if (!m_en[d] && prev_en[d]) begin
                    chk($sformatf("d%0d tx_en length", d), run[d], cur_len[d]);
                    run[d] = 0; gapc[d] = 0; in_gap[d] = 1'b1;
                end
                if (in_gap[d] && !m_en[d] && m_act[d]) begin
                    gapc[d]++;
                    chk($sformatf("d%0d gap tx_data", d), m_data[d], 8'h00);
                end
                if (in_gap[d] && prev_act[d] && !m_act[d]) begin
                    chk($sformatf("d%0d gap cycles", d), gapc[d], ifg_of(d));
                    in_gap[d] = 1'b0;
                end
                prev_en[d]  = m_en[d];
                prev_act[d] = m_act[d];
            end
        end
        if (rst) begin
            exp_q.delete();
            frm_q.delete();
        end
    end

    // Queues the expected frame for payload pl, then drives it; abort_at>0 resets after that many bytes
    task automatic send(input int d, input int abort_at, input bit wait_idle);
        logic [7:0]  body [$];
        logic [31:0] c;
        frm_t        f;
        body = pl;
        while (body.size() < min_of(d)) body.push_back(8'h00);
        f.d = d;
        f.rise = cyc + 1;
        f.len = pl_of(d) + body.size() + FCS_N;
        frm_q.push_back(f);
        for (int i = 0; i < pl_of(d) - 1; i++) push_b(d, 8'h55);
        push_b(d, 8'hD5);
        foreach (body[i]) push_b(d, body[i]);
        c = crc32(body);
        for (int i = 0; i < FCS_N; i++) push_b(d, c[8*i +: 8]);
        for (int i = 0; i < pl.size(); i++) begin
            if (abort_at > 0 && i == abort_at) begin
                en[d] = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                chk("reset tx_en", m_en[d], 1'b0);
                chk("reset tx_data", m_data[d], 8'h00);
                chk("reset active", m_act[d], 1'b0);
                chk("reset dropped", m_drop[d], 1'b0);
                chk("reset tx_ready", m_rdy[d], 1'b1);
                rst = 1'b0;
                return;
            end
            en[d] = 1'b1;
            din[d] = pl[i];
            @(posedge clk); #1;
        end
        en[d] = 1'b0;
        if (wait_idle) begin
            for (int t = 0; t < 400 && m_act[d]; t++) begin
                @(posedge clk); #1;
            end
            if (m_act[d]) fail_now($sformatf("d%0d idle wait: got active=1 after 400 cycles, expected 0", d));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got no finish by 2 ms, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        din[0] = 8'h00;
        din[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d init tx_en", d), m_en[d], 1'b0);
            chk($sformatf("d%0d init tx_data", d), m_data[d], 8'h00);
            chk($sformatf("d%0d init active", d), m_act[d], 1'b0);
            chk($sformatf("d%0d init dropped", d), m_drop[d], 1'b0);
            chk($sformatf("d%0d init tx_ready", d), m_rdy[d], 1'b1);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        pl.delete(); pl.push_back(8'hAB);
        send(0, 0, 1'b1);

        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        send(1, 0, 1'b1);

        pl.delete(); pl.push_back(8'hAB);
        send(1, 0, 1'b1);

        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i));
        send(0, 0, 1'b1);

        pl.delete();
        for (int i = 1; i <= 5; i++) pl.push_back(8'(i));
        send(0, 0, 1'b0);
        for (int t = 0; t < 300 && m_en[0]; t++) begin
            @(posedge clk); #1;
        end
        chk("b2b in gap tx_en", m_en[0], 1'b0);
        chk("b2b in gap tx_ready", m_rdy[0], 1'b0);
        en[0] = 1'b1;
        din[0] = 8'hEE;
        drop_q.push_back(0);
        for (int t = 0; t < 100 && m_act[0]; t++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("b2b held start refused", m_act[0], 1'b0);
        chk("b2b idle tx_ready", m_rdy[0], 1'b1);
        en[0] = 1'b0;
        @(posedge clk); #1;
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        send(0, 0, 1'b1);

        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i * 3 + 7));
        send(0, 25, 1'b0);
        send(0, 0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("leftover bytes", exp_q.size(), 0);
        chk("leftover frames", frm_q.size(), 0);
        chk("leftover drops", drop_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
